// File: rtl/seq_detect_sched_if.sv
// Bundles the requester-side bit streams and the match report of the
// shared pattern detector. The master drives the streams; the slave is the detector.
interface seq_detect_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              en;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_bit;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH-1:0] clr_ch;
  logic              match_vld;
  logic [CH_W-1:0]   match_ch;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output en, in_valid, in_bit, clr_ch,
    input  in_ready, match_vld, match_ch, match_cnt
  );

  modport slave (
    input  en, in_valid, in_bit, clr_ch,
    output in_ready, match_vld, match_ch, match_cnt
  );
endinterface

// File: rtl/seq_detect_sched.sv
// Shared overlapping serial pattern detector, time-multiplexed over NUM_CH
// bit streams by a round-robin arbiter. Each channel keeps its own detector
// context (matched prefix length) and a saturating match counter.
module seq_detect_sched #(
  parameter int                 NUM_CH  = 4,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_sched_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CTX_W = $clog2(PAT_LEN);
  localparam int TBL_W = 2 * PAT_LEN * CTX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Next-context table, entry (s*2 + b): longest suffix of the first s
  // pattern bits followed by b that is a proper prefix of the pattern.
  // On a full match this yields the longest proper border, so overlapping
  // occurrences are found without a separate case.
  function automatic logic [TBL_W-1:0] build_nxt();
    logic [TBL_W-1:0]   tbl;
    logic [PAT_LEN-1:0] str;
    logic               ok;
    int                 best;
    tbl = '0;
    for (int s = 0; s < PAT_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        str = '0;
        for (int j = 0; j < PAT_LEN; j++)
          if (j < s) str[j] = PATTERN[PAT_LEN-1-j];
        str[s] = b[0];
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
          if (k <= s + 1) begin
            ok = 1'b1;
            for (int j = 0; j < PAT_LEN; j++)
              if (j < k && str[s+1-k+j] != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
            if (ok) best = k;
          end
        end
        tbl[(s*2+b)*CTX_W +: CTX_W] = best[CTX_W-1:0];
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NXT_TBL = build_nxt();

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ptr_nxt;
  logic [CH_W-1:0]   scan_idx;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] clr_eff;
  logic              gnt_any;

  logic [CTX_W-1:0]  ctx [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];

  logic              bit_sel;
  logic [CTX_W-1:0]  ctx_sel;
  logic [CTX_W-1:0]  ctx_nxt;
  logic [CNT_W-1:0]  cnt_sel;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              hit;

  logic              match_vld_q;
  logic [CH_W-1:0]   match_ch_q;
  logic [CNT_W-1:0]  match_cnt_q;

  // A channel being cleared is never granted in the same cycle, and en=0
  // freezes everything, clears included.
  assign elig    = bus.in_valid & ~bus.clr_ch & {NUM_CH{bus.en}};
  assign clr_eff = bus.clr_ch & {NUM_CH{bus.en}};

  // Round-robin search: first eligible channel starting at ptr.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = wrap_add(ptr, i);
      if (!gnt_any && elig[scan_idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
    ptr_nxt = wrap_add(gnt_idx, 1);
  end

  // Shared detector datapath operating on the granted channel's context.
  always_comb begin
    bit_sel = bus.in_bit[gnt_idx];
    ctx_sel = ctx[gnt_idx];
    cnt_sel = cnt[gnt_idx];
    hit     = gnt_any && (int'(ctx_sel) == PAT_LEN - 1) && (bit_sel == PATTERN[0]);
    ctx_nxt = NXT_TBL[(int'(ctx_sel) * 2 + int'(bit_sel)) * CTX_W +: CTX_W];
    cnt_nxt = (cnt_sel == CNT_MAX) ? cnt_sel : cnt_sel + 1'b1;
  end

  // Pointer advances past the granted channel; holds when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= ptr_nxt;
    end
  end

  // Per-channel context and counter save/restore.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctx[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_eff[i]) begin
          ctx[i] <= '0;
          cnt[i] <= '0;
        end else if (grant[i]) begin
          ctx[i] <= ctx_nxt;
          if (hit) cnt[i] <= cnt_nxt;
        end
      end
    end
  end

  // Registered match report; channel and count hold between matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_vld_q <= 1'b0;
      match_ch_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      match_vld_q <= hit;
      if (hit) begin
        match_ch_q  <= gnt_idx;
        match_cnt_q <= cnt_nxt;
      end
    end
  end

  assign bus.in_ready  = grant;
  assign bus.match_vld = match_vld_q;
  assign bus.match_ch  = match_ch_q;
  assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: one instance with 8-bit counters for
// the main scenarios and one with 2-bit counters for saturation.
module tb_seq_detect_sched;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  seq_detect_sched_if #(.NUM_CH(4), .CNT_W(8)) bus_a ();
  seq_detect_sched_if #(.NUM_CH(4), .CNT_W(2)) bus_b ();

  seq_detect_sched #(.NUM_CH(4), .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  seq_detect_sched #(.NUM_CH(4), .PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int ch, input logic b);
    bus_a.in_valid = 4'b0001 << ch;
    bus_a.in_bit   = b ? (4'b0001 << ch) : 4'b0000;
    tick();
    bus_a.in_valid = '0;
  endtask

  task automatic send_b(input int ch, input logic b);
    bus_b.in_valid = 4'b0001 << ch;
    bus_b.in_bit   = b ? (4'b0001 << ch) : 4'b0000;
    tick();
    bus_b.in_valid = '0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (bus_a.match_vld !== 1'b0 || bus_a.match_ch !== 2'd0 || bus_a.match_cnt !== 8'd0) begin
      $display("FAIL reset_a: got vld=%0b ch=%0d cnt=%0d expected 0/0/0", bus_a.match_vld, bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
    total++;
    if (bus_b.match_vld !== 1'b0 || bus_b.match_cnt !== 2'd0) begin
      $display("FAIL reset_b: got vld=%0b cnt=%0d expected 0/0", bus_b.match_vld, bus_b.match_cnt);
    end else passed++;
    tick();
    reset = 1'b0;
    tick();
    bus_a.in_valid = 4'b0100;
    #1;
    total++;
    if (bus_a.in_ready !== 4'b0100) begin
      $display("FAIL ready_single: got %b expected 0100", bus_a.in_ready);
    end else passed++;
    bus_a.in_valid = 4'b0000;
    #1;
    total++;
    if (bus_a.in_ready !== 4'b0000) begin
      $display("FAIL ready_none: got %b expected 0000", bus_a.in_ready);
    end else passed++;
  endtask

  // T1: ch0 1011 -> one match.
  task automatic test_single();
    logic [3:0] seq = 4'b1011;
    logic       exp;
    for (int i = 0; i < 4; i++) begin
      send_a(0, seq[3-i]);
      exp = (i == 3);
      total++;
      if (bus_a.match_vld !== exp) begin
        $display("FAIL t1_vld[%0d]: got %0b expected %0b", i, bus_a.match_vld, exp);
      end else passed++;
    end
    total++;
    if (bus_a.match_ch !== 2'd0 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL t1_tag: got ch=%0d cnt=%0d expected 0/1", bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
    tick();
    total++;
    if (bus_a.match_vld !== 1'b0 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL t1_hold: got vld=%0b cnt=%0d expected 0/1", bus_a.match_vld, bus_a.match_cnt);
    end else passed++;
  endtask

  // T2: clear ch0, then 1011011 -> overlapping matches after accepts 4 and 7.
  task automatic test_overlap();
    logic [6:0] seq = 7'b1011011;
    logic       exp;
    bus_a.clr_ch = 4'b0001;
    tick();
    bus_a.clr_ch = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      send_a(0, seq[6-i]);
      exp = (i == 3) || (i == 6);
      total++;
      if (bus_a.match_vld !== exp) begin
        $display("FAIL t2_vld[%0d]: got %0b expected %0b", i, bus_a.match_vld, exp);
      end else passed++;
      if (exp) begin
        total++;
        if (bus_a.match_cnt !== ((i == 3) ? 8'd1 : 8'd2) || bus_a.match_ch !== 2'd0) begin
          $display("FAIL t2_cnt[%0d]: got ch=%0d cnt=%0d expected 0/%0d", i, bus_a.match_ch, bus_a.match_cnt, (i == 3) ? 1 : 2);
        end else passed++;
      end
    end
  endtask

  // T3: ch1 11011 (s1 self-loop) then 101011 (s3 on 0 falls back to s2).
  task automatic test_fallback();
    logic [10:0] seq = 11'b11011_101011;
    logic        exp;
    for (int i = 0; i < 11; i++) begin
      send_a(1, seq[10-i]);
      exp = (i == 4) || (i == 10);
      total++;
      if (bus_a.match_vld !== exp) begin
        $display("FAIL t3_vld[%0d]: got %0b expected %0b", i, bus_a.match_vld, exp);
      end else passed++;
      if (exp) begin
        total++;
        if (bus_a.match_ch !== 2'd1 || bus_a.match_cnt !== ((i == 4) ? 8'd1 : 8'd2)) begin
          $display("FAIL t3_tag[%0d]: got ch=%0d cnt=%0d expected 1/%0d", i, bus_a.match_ch, bus_a.match_cnt, (i == 4) ? 1 : 2);
        end else passed++;
      end
    end
  endtask

  // T4: ch0 and ch1 both valid every cycle; grants alternate starting at ch0
  // (pointer sits at 2 after ch1's last grant). ch0 streams 1011 twice, ch1 zeros.
  task automatic test_back_to_back();
    logic [3:0] pat = 4'b1011;
    logic [3:0] exp_rdy;
    logic       exp;
    bus_a.clr_ch = 4'b0011;
    tick();
    bus_a.clr_ch = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      bus_a.in_valid = 4'b0011;
      bus_a.in_bit   = {3'b000, pat[3 - ((c / 2) % 4)]};
      #1;
      exp_rdy = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      total++;
      if (bus_a.in_ready !== exp_rdy) begin
        $display("FAIL t4_rdy[%0d]: got %b expected %b", c, bus_a.in_ready, exp_rdy);
      end else passed++;
      tick();
      exp = (c == 6) || (c == 14);
      total++;
      if (bus_a.match_vld !== exp) begin
        $display("FAIL t4_vld[%0d]: got %0b expected %0b", c, bus_a.match_vld, exp);
      end else passed++;
      if (exp) begin
        total++;
        if (bus_a.match_ch !== 2'd0 || bus_a.match_cnt !== ((c == 6) ? 8'd1 : 8'd2)) begin
          $display("FAIL t4_tag[%0d]: got ch=%0d cnt=%0d expected 0/%0d", c, bus_a.match_ch, bus_a.match_cnt, (c == 6) ? 1 : 2);
        end else passed++;
      end
    end
    bus_a.in_valid = 4'b0000;
    bus_a.in_bit   = 4'b0000;
  endtask

  // en=0 mid-stream on ch1: no grants, context kept, stream resumes.
  task automatic test_enable();
    bus_a.clr_ch = 4'b0010;
    tick();
    bus_a.clr_ch = 4'b0000;
    send_a(1, 1'b1);
    send_a(1, 1'b0);
    bus_a.en       = 1'b0;
    bus_a.in_valid = 4'b0010;
    bus_a.in_bit   = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus_a.in_ready !== 4'b0000) begin
        $display("FAIL en_rdy[%0d]: got %b expected 0000", c, bus_a.in_ready);
      end else passed++;
      tick();
      total++;
      if (bus_a.match_vld !== 1'b0) begin
        $display("FAIL en_vld[%0d]: got %0b expected 0", c, bus_a.match_vld);
      end else passed++;
    end
    bus_a.in_valid = 4'b0000;
    bus_a.en       = 1'b1;
    send_a(1, 1'b1);
    total++;
    if (bus_a.match_vld !== 1'b0) begin
      $display("FAIL en_resume3: got %0b expected 0", bus_a.match_vld);
    end else passed++;
    send_a(1, 1'b1);
    total++;
    if (bus_a.match_vld !== 1'b1 || bus_a.match_ch !== 2'd1 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL en_resume4: got vld=%0b ch=%0d cnt=%0d expected 1/1/1", bus_a.match_vld, bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
  endtask

  // clr_ch on ch2 blocks its grant and wipes its context; ch3 unaffected.
  task automatic test_clear();
    logic [3:0] seq = 4'b1011;
    for (int i = 0; i < 3; i++) send_a(3, seq[3-i]);
    for (int i = 0; i < 3; i++) send_a(2, seq[3-i]);
    bus_a.clr_ch   = 4'b0100;
    bus_a.in_valid = 4'b1100;
    bus_a.in_bit   = 4'b1100;
    #1;
    total++;
    if (bus_a.in_ready !== 4'b1000) begin
      $display("FAIL clr_rdy: got %b expected 1000", bus_a.in_ready);
    end else passed++;
    tick();
    bus_a.clr_ch   = 4'b0000;
    bus_a.in_valid = 4'b0000;
    total++;
    if (bus_a.match_vld !== 1'b1 || bus_a.match_ch !== 2'd3 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL clr_other: got vld=%0b ch=%0d cnt=%0d expected 1/3/1", bus_a.match_vld, bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
    send_a(2, 1'b1);
    total++;
    if (bus_a.match_vld !== 1'b0) begin
      $display("FAIL clr_ctx: got %0b expected 0", bus_a.match_vld);
    end else passed++;
    send_a(2, 1'b0);
    send_a(2, 1'b1);
    send_a(2, 1'b1);
    total++;
    if (bus_a.match_vld !== 1'b1 || bus_a.match_ch !== 2'd2 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL clr_after: got vld=%0b ch=%0d cnt=%0d expected 1/2/1", bus_a.match_vld, bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
  endtask

  // T5: 2-bit counter on ch2 saturates at 3; clear restarts at 1.
  task automatic test_saturate();
    logic [3:0] seq = 4'b1011;
    logic [1:0] exp_cnt;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) send_b(2, seq[3-i]);
      exp_cnt = (r >= 2) ? 2'd3 : 2'(r + 1);
      total++;
      if (bus_b.match_vld !== 1'b1 || bus_b.match_ch !== 2'd2 || bus_b.match_cnt !== exp_cnt) begin
        $display("FAIL sat[%0d]: got vld=%0b ch=%0d cnt=%0d expected 1/2/%0d", r, bus_b.match_vld, bus_b.match_ch, bus_b.match_cnt, exp_cnt);
      end else passed++;
    end
    bus_b.clr_ch = 4'b0100;
    tick();
    bus_b.clr_ch = 4'b0000;
    for (int i = 0; i < 4; i++) send_b(2, seq[3-i]);
    total++;
    if (bus_b.match_vld !== 1'b1 || bus_b.match_cnt !== 2'd1) begin
      $display("FAIL sat_clr: got vld=%0b cnt=%0d expected 1/1", bus_b.match_vld, bus_b.match_cnt);
    end else passed++;
  endtask

  // T6: reset after ch3 received 1,0,1 with the 4th bit in flight.
  task automatic test_reset_mid();
    logic [3:0] seq = 4'b1011;
    logic       exp;
    for (int i = 0; i < 3; i++) send_a(3, seq[3-i]);
    bus_a.in_valid = 4'b1000;
    bus_a.in_bit   = 4'b1000;
    #2;
    reset = 1'b1;
    tick();
    bus_a.in_valid = 4'b0000;
    total++;
    if (bus_a.match_vld !== 1'b0 || bus_a.match_ch !== 2'd0 || bus_a.match_cnt !== 8'd0) begin
      $display("FAIL rst_mid_a: got vld=%0b ch=%0d cnt=%0d expected 0/0/0", bus_a.match_vld, bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
    total++;
    if (bus_b.match_ch !== 2'd0 || bus_b.match_cnt !== 2'd0) begin
      $display("FAIL rst_mid_b: got ch=%0d cnt=%0d expected 0/0", bus_b.match_ch, bus_b.match_cnt);
    end else passed++;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      send_a(3, seq[3-i]);
      exp = (i == 3);
      total++;
      if (bus_a.match_vld !== exp) begin
        $display("FAIL rst_new[%0d]: got %0b expected %0b", i, bus_a.match_vld, exp);
      end else passed++;
    end
    total++;
    if (bus_a.match_ch !== 2'd3 || bus_a.match_cnt !== 8'd1) begin
      $display("FAIL rst_new_tag: got ch=%0d cnt=%0d expected 3/1", bus_a.match_ch, bus_a.match_cnt);
    end else passed++;
  endtask

  initial begin
    reset          = 1'b1;
    bus_a.en       = 1'b1;
    bus_a.in_valid = '0;
    bus_a.in_bit   = '0;
    bus_a.clr_ch   = '0;
    bus_b.en       = 1'b1;
    bus_b.in_valid = '0;
    bus_b.in_bit   = '0;
    bus_b.clr_ch   = '0;
    test_reset();
    test_single();
    test_overlap();
    test_fallback();
    test_back_to_back();
    test_enable();
    test_clear();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
